// File: rtl/node_layer_feeder.sv
// Serial-to-parallel activation feeder for a layer node: fills a 10-byte shadow,
// transfers it onto A0x..A9x and flags res_valid once the node output has settled.
// Optional build macro FEEDER_RELU_CLAMP_EN stores negative input bytes as zero.
module node_layer_feeder #(
  parameter int NODE_LAT = 3,
  parameter int LAT_W    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [7:0] A0x,
  output logic [7:0] A1x,
  output logic [7:0] A2x,
  output logic [7:0] A3x,
  output logic [7:0] A4x,
  output logic [7:0] A5x,
  output logic [7:0] A6x,
  output logic [7:0] A7x,
  output logic [7:0] A8x,
  output logic [7:0] A9x,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [1:0] dbg_state_o
);

  // Handshakes: a byte moves when in_valid & in_ready at a rising edge; the
  // result is taken when res_valid & res_ready at a rising edge.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t           state_q;
  logic [LAT_W-1:0] lat_q;
  logic [3:0]       cnt_q;
  logic [7:0]       sh_q [10];
  logic [7:0]       a_q  [10];
  logic [7:0]       in_byte;
  logic             accept;
  logic             xfer;

`ifdef FEEDER_RELU_CLAMP_EN
  assign in_byte = in_data[7] ? 8'd0 : in_data;
`else
  assign in_byte = in_data;
`endif

  assign in_ready = ~reset & (cnt_q < 4'd10) & ~flush;
  assign accept   = in_valid & in_ready;
  // A full shadow can only move when the drive vector is free or being released.
  assign xfer     = (cnt_q == 4'd10) &
                    ((state_q == ST_IDLE) | ((state_q == ST_VALID) & res_ready));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
      for (int i = 0; i < 10; i++) sh_q[i] <= 8'd0;
    end else begin
      if (accept) sh_q[cnt_q] <= in_byte;
      if (xfer || flush)  cnt_q <= 4'd0;
      else if (accept)    cnt_q <= cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      for (int i = 0; i < 10; i++) a_q[i] <= 8'd0;
    end else begin
      if (xfer) begin
        for (int i = 0; i < 10; i++) a_q[i] <= sh_q[i];
        lat_q   <= LAT_W'(NODE_LAT - 1);
        state_q <= ST_WAIT;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_WAIT: begin
            if (lat_q == '0) state_q <= ST_VALID;
            else             lat_q   <= lat_q - LAT_W'(1);
          end
          ST_VALID: if (res_ready) state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign res_valid   = (state_q == ST_VALID);
  assign dbg_state_o = state_q;

  assign A0x = a_q[0];
  assign A1x = a_q[1];
  assign A2x = a_q[2];
  assign A3x = a_q[3];
  assign A4x = a_q[4];
  assign A5x = a_q[5];
  assign A6x = a_q[6];
  assign A7x = a_q[7];
  assign A8x = a_q[8];
  assign A9x = a_q[9];

endmodule

// File: tb/tb_node_layer_feeder.sv
// Directed bench for node_layer_feeder: fill/transfer timing, backpressure,
// flush, async reset mid-wait, optional clamp and gapped input traffic.
module tb_node_layer_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] A0x, A1x, A2x, A3x, A4x, A5x, A6x, A7x, A8x, A9x;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] dbg_state;
  logic [79:0] a_vec;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int rise_cnt = 0;
  logic rv_prev = 1'b0;
  logic rv_seen;
  logic [79:0] exp_q[$];
  logic [7:0]  clamp_exp;

  node_layer_feeder #(.NODE_LAT(3), .LAT_W(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush),
    .A0x(A0x), .A1x(A1x), .A2x(A2x), .A3x(A3x), .A4x(A4x),
    .A5x(A5x), .A6x(A6x), .A7x(A7x), .A8x(A8x), .A9x(A9x),
    .res_valid(res_valid), .res_ready(res_ready), .dbg_state_o(dbg_state)
  );

  assign a_vec = {A9x, A8x, A7x, A6x, A5x, A4x, A3x, A2x, A1x, A0x};

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] mk_vec(input logic [7:0] base);
    logic [79:0] v;
    for (int i = 0; i < 10; i++) v[i*8 +: 8] = base + 8'(i);
    return v;
  endfunction

  function automatic logic [79:0] fill_vec(input logic [7:0] b);
    logic [79:0] v;
    for (int i = 0; i < 10; i++) v[i*8 +: 8] = b;
    return v;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("ready_timeout", 80'd0, 80'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rv();
    int n;
    n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("rv_timeout", 80'd0, 80'd1);
  endtask

  // Scoreboard: every res_valid rise must present the next expected vector
  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cnt++;
    if (res_valid && !rv_prev) begin
      rise_cnt++;
      if (exp_q.size() == 0) chk("spurious_rv", 80'd1, 80'd0);
      else                   chk("vec", a_vec, exp_q.pop_front());
    end
    rv_prev = res_valid;
  end

  initial begin
    reset = 1'b1; in_data = 8'd0; in_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
`ifdef FEEDER_RELU_CLAMP_EN
    clamp_exp = 8'h00;
`else
    clamp_exp = 8'hF0;
`endif
    #2;
    chk("rst_ready", 80'(in_ready), 80'd0);
    chk("rst_rv", 80'(res_valid), 80'd0);
    chk("rst_avec", a_vec, 80'd0);
    chk("rst_state", 80'(dbg_state), 80'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 80'(in_ready), 80'd1);

    // Basic fill, transfer and latency
    exp_q.push_back(mk_vec(8'd1));
    for (int i = 1; i <= 10; i++) send_byte(8'(i));
    in_valid = 1'b0;
    chk("full_ready", 80'(in_ready), 80'd0);
    chk("pre_xfer_a0", 80'(A0x), 80'd0);
    tick();
    chk("xfer_avec", a_vec, mk_vec(8'd1));
    chk("xfer_rv", 80'(res_valid), 80'd0);
    tick(); tick();
    chk("lat2_rv", 80'(res_valid), 80'd0);
    tick();
    chk("lat3_rv", 80'(res_valid), 80'd1);
    tick();
    chk("rv_pulse_end", 80'(res_valid), 80'd0);
    chk("back_idle", 80'(dbg_state), 80'd0);

    // Backpressure and back-to-back transfer
    res_ready = 1'b0;
    exp_q.push_back(mk_vec(8'd10));
    exp_q.push_back(mk_vec(8'd20));
    for (int i = 10; i <= 29; i++) send_byte(8'(i));
    in_valid = 1'b0;
    chk("bp_ready", 80'(in_ready), 80'd0);
    chk("bp_rv", 80'(res_valid), 80'd1);
    chk("bp_a0", 80'(A0x), 80'd10);
    res_ready = 1'b1;
    tick();
    chk("b2b_a0", 80'(A0x), 80'd20);
    chk("b2b_rv_drop", 80'(res_valid), 80'd0);
    tick(); tick();
    chk("b2b_lat2", 80'(res_valid), 80'd0);
    tick();
    chk("b2b_lat3", 80'(res_valid), 80'd1);
    tick(); tick();

    // Flush of a partial shadow
    for (int i = 0; i < 4; i++) send_byte(8'(50 + i));
    in_data = 8'd99; flush = 1'b1;
    #1;
    chk("flush_ready", 80'(in_ready), 80'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.push_back(mk_vec(8'd60));
    for (int i = 0; i < 10; i++) send_byte(8'(60 + i));
    in_valid = 1'b0;
    wait_rv();
    chk("flush_a0", 80'(A0x), 80'd60);
    tick(); tick();

    // Async reset in the middle of WAIT
    for (int i = 0; i < 10; i++) send_byte(8'(70 + i));
    in_valid = 1'b0;
    tick(); tick();
    chk("wait_state", 80'(dbg_state), 80'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_avec", a_vec, 80'd0);
    chk("async_rv", 80'(res_valid), 80'd0);
    chk("async_ready", 80'(in_ready), 80'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rel_ready", 80'(in_ready), 80'd1);
    rv_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      rv_seen = rv_seen | res_valid;
    end
    chk("no_spurious_rv", 80'(rv_seen), 80'd0);

    // Negative activations
    exp_q.push_back(fill_vec(clamp_exp));
    for (int i = 0; i < 10; i++) send_byte(8'hF0);
    in_valid = 1'b0;
    wait_rv();
    chk("clamp_a9", 80'(A9x), 80'(clamp_exp));
    tick(); tick();

    // Gapped input traffic across two vectors
    exp_q.push_back(mk_vec(8'd100));
    exp_q.push_back(mk_vec(8'd110));
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(100 + i));
      in_valid = 1'b0;
      tick();
    end
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
    tick(); tick();

    chk("exp_q_empty", 80'(exp_q.size()), 80'd0);
    chk("accept_total", 80'(acc_cnt), 80'd84);
    chk("rv_rises", 80'(rise_cnt), 80'd7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
